// File: rtl/writeback_sequencer.sv
// Register-file write-back sequencer: accepts one tagged request, waits on memory
// latency or a busy unit, then issues a single-cycle write with registered outputs.
module writeback_sequencer #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned SP_REG      = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_start,
  input  logic [2:0] wb_source,
  input  logic [4:0] wb_dest,
  input  logic       shift_busy,
  input  logic       multdiv_busy,
  output logic [2:0] MemToReg,
  output logic [4:0] WriteReg,
  output logic       RegWrite,
  output logic       MDRLoad,
  output logic       wb_ready,
  output logic       wb_done,
  output logic       wb_error
);

  localparam int unsigned SRC_W = 3;
  localparam int unsigned REG_W = 5;
  localparam int unsigned MEM_W = 4;
  localparam int unsigned TO_W  = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEM_WAIT  = 2'd1,
    UNIT_WAIT = 2'd2,
    WRITE     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [REG_W-1:0]   dest_q, dest_d;
  logic [MEM_W-1:0]   mem_cnt_q, mem_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

  logic [SRC_W-1:0]   mem_to_reg_q, mem_to_reg_d;
  logic [REG_W-1:0]   write_reg_q, write_reg_d;
  logic               reg_write_q, reg_write_d;
  logic               mdr_load_q, mdr_load_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               sel_busy;
  logic [REG_W-1:0]   eff_dest_d;
  logic               in_write_d;

  // Source 4 waits on the shifter; sources 2/3 wait on mult/div.
  assign sel_busy = (src_q == SRC_W'(4)) ? shift_busy : multdiv_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dest_q       <= '0;
      mem_cnt_q    <= '0;
      to_cnt_q     <= '0;
      mem_to_reg_q <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mdr_load_q   <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dest_q       <= dest_d;
      mem_cnt_q    <= mem_cnt_d;
      to_cnt_q     <= to_cnt_d;
      mem_to_reg_q <= mem_to_reg_d;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write_d;
      mdr_load_q   <= mdr_load_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dest_d    = dest_q;
    mem_cnt_d = mem_cnt_q;
    to_cnt_d  = to_cnt_q;
    error_d   = 1'b0;

    case (state_q)
      IDLE, WRITE: begin
        if (state_q == WRITE) state_d = IDLE;
        if (wb_start) begin
          src_d  = wb_source;
          dest_d = wb_dest;
          case (wb_source)
            3'd1, 3'd5: begin
              state_d   = MEM_WAIT;
              mem_cnt_d = MEM_W'(MEM_LATENCY);
            end
            3'd2, 3'd3, 3'd4: begin
              state_d  = UNIT_WAIT;
              to_cnt_d = '0;
            end
            default: state_d = WRITE;
          endcase
        end
      end
      MEM_WAIT: begin
        mem_cnt_d = mem_cnt_q - MEM_W'(1);
        if (mem_cnt_q <= MEM_W'(1)) state_d = WRITE;
      end
      UNIT_WAIT: begin
        if (!sel_busy) begin
          state_d = WRITE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_d == TO_W'(TIMEOUT)) begin
            state_d = IDLE;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    in_write_d   = (state_d == WRITE);
    eff_dest_d   = (src_d == SRC_W'(7)) ? REG_W'(SP_REG) : dest_d;
    mem_to_reg_d = (state_d == IDLE) ? '0 : src_d;
    write_reg_d  = in_write_d ? eff_dest_d : '0;
    reg_write_d  = in_write_d && (eff_dest_d != '0);
    done_d       = in_write_d;
    mdr_load_d   = (state_d == MEM_WAIT) && (mem_cnt_d == MEM_W'(1));
    ready_d      = (state_d == IDLE) || (state_d == WRITE);
  end

  assign MemToReg = mem_to_reg_q;
  assign WriteReg = write_reg_q;
  assign RegWrite = reg_write_q;
  assign MDRLoad  = mdr_load_q;
  assign wb_ready = ready_q;
  assign wb_done  = done_q;
  assign wb_error = error_q;

endmodule

// File: doc/writeback_sequencer.md
# writeback_sequencer

Sequences register-file write-back in the multicycle datapath. It accepts one write-back request at a time, tagged with its data source and destination register. For sources that are not yet valid, it waits until the memory latency has elapsed or the shifter/mult-div unit is idle. It then drives the write-back mux select, destination register and a single-cycle `RegWrite`. It sits between the main control FSM and the register file / write-back mux.

## Interface
Parameters:
- `MEM_LATENCY`, default 2: number of cycles memory data needs before `MDRLoad`. Legal range 1..15.
- `TIMEOUT`, default 64: maximum number of cycles to wait on a busy unit. Legal range 1..255.
- `SP_REG`, default 29: destination register forced for source 7 (reset SP).

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `wb_start` in 1: request strobe. Sampled only while `wb_ready` = 1.
- `wb_source` in 3: data source. 0 ALUOut, 1 MDR, 2 HI, 3 LO, 4 shift reg, 5 load unit, 6 SLT flag, 7 reset SP.
- `wb_dest` in 5: destination register number.
- `shift_busy` in 1: shifter is still computing.
- `multdiv_busy` in 1: mult/div unit is still computing.
- `MemToReg` out 3: write-back mux select.
- `WriteReg` out 5: register-file write address.
- `RegWrite` out 1: register-file write enable.
- `MDRLoad` out 1: memory data register load strobe.
- `wb_ready` out 1: a new request can be accepted.
- `wb_done` out 1: write-back completed (one-cycle pulse).
- `wb_error` out 1: timeout abort (one-cycle pulse).

## Operation
States: IDLE, MEM_WAIT, UNIT_WAIT, WRITE.

- **Reset** (asynchronous, `reset` = 0):
  - State goes to IDLE.
  - All outputs are 0 except `wb_ready` = 1.
  - Counters and latched source/dest are 0.
- **Request acceptance.** `wb_ready` = 1 in IDLE and WRITE. When `wb_start` = 1 is sampled in either state, `wb_source` and `wb_dest` are latched and the next state is:
  - sources 1 and 5: MEM_WAIT, memory counter loaded with `MEM_LATENCY`;
  - sources 2 and 3: UNIT_WAIT on `multdiv_busy`, timeout counter cleared;
  - source 4: UNIT_WAIT on `shift_busy`, timeout counter cleared;
  - sources 0, 6 and 7: WRITE directly.
- **Busy requests.** `wb_start` in MEM_WAIT or UNIT_WAIT is ignored. No queueing, no error.
- **MEM_WAIT.**
  - The counter decrements once per cycle.
  - `MDRLoad` = 1 during the cycle in which the counter equals 1.
  - The next state after that cycle is WRITE.
- **UNIT_WAIT.**
  - If the selected busy input is sampled 0, the next state is WRITE.
  - Otherwise the timeout counter increments. When it reaches `TIMEOUT`:
    - `wb_error` pulses for one cycle;
    - state returns to IDLE;
    - no write occurs.
- **WRITE** (exactly one cycle):
  - `MemToReg` = latched source.
  - `WriteReg` = latched dest, or `SP_REG` when the source is 7.
  - `RegWrite` = 1 unless the effective `WriteReg` is 0; register 0 is never written.
  - `wb_done` = 1 regardless of that suppression.
  - Next state is IDLE, or the new request's state if `wb_start` is sampled this cycle.
- **Outputs outside WRITE.**
  - `MemToReg` holds the latched source in MEM_WAIT, UNIT_WAIT and WRITE, and is 0 in IDLE.
  - `WriteReg` is 0 outside WRITE.
- **Width rules.**
  - The memory counter is 4 bits; the timeout counter is 8 bits.
  - Neither counter wraps: each is reloaded on every accepted request.

## Timing
- Request accepted at edge N.
  - Sources 0/6/7: `RegWrite` and `wb_done` are high in cycle N+1.
  - Sources 1/5: `MDRLoad` is high in cycle N+`MEM_LATENCY`; WRITE is cycle N+`MEM_LATENCY`+1.
  - Sources 2/3/4: WRITE is the cycle after the first edge at which the selected busy input is sampled 0. Minimum latency is 2 cycles.
- **Back-to-back requests.** A request accepted during WRITE gives zero idle cycles between write-backs. The sustained rate for ALU sources is one write per cycle.
- **Reset mid-operation.** Any in-flight request is dropped immediately and no `RegWrite` is emitted. Reset deassertion takes effect on the next rising edge.
- **Outputs are registered.** Every output is a function of state and latched data only. The busy inputs do not combinationally reach any output.

## Test plan
- **Reset behaviour.** Hold `reset` = 0 while toggling every input. Require all outputs 0 except `wb_ready` = 1. Deassert reset, then issue source 0, dest 8: `RegWrite` is high exactly one cycle later with `WriteReg` = 8 and `MemToReg` = 0.
- **Memory source.** `MEM_LATENCY` = 3, source 5, dest 12. Require:
  - `MDRLoad` high only in cycle N+3;
  - `RegWrite` in cycle N+4 with `MemToReg` = 5 and `WriteReg` = 12;
  - a second `wb_start` issued during the wait has no effect.
- **Mult/div wait.** Source 2, dest 9, `multdiv_busy` held high 5 cycles then released. Require `RegWrite` exactly one cycle after busy is sampled low. A repeat with busy held high for `TIMEOUT` = 8 cycles must give one `wb_error` pulse, no `RegWrite`, and a return to IDLE.
- **Register 0 and SP.** Source 0, dest 0: `wb_done` = 1 while `RegWrite` = 0. Source 7, dest 3: `WriteReg` = 29, `MemToReg` = 7, `RegWrite` = 1.
- **Back-to-back ALU.** Three consecutive source-0 requests with dests 4, 5 and 6, starts on consecutive cycles. Require `RegWrite` high for 3 consecutive cycles with `WriteReg` = 4, 5, 6.
- **Reset mid-wait.** Assert `reset` during MEM_WAIT of a source-1 request. Require `MDRLoad` and `RegWrite` never to assert for that request, and the block to be ready on the first cycle after release.
